// File: rtl/alarm_clock_core_if.sv
// Button-pulse inputs and display/buzzer outputs of the alarm clock core.
// The core connects through the slave modport; the driver of the buttons and
// consumer of the outputs connects through the master modport.
interface alarm_clock_core_if #(
  parameter int NUM_ALARMS = 2
);
  logic                  i_mode_p;
  logic                  i_pos_p;
  logic                  i_inc_p;
  logic                  i_sel_p;
  logic                  i_en_p;
  logic                  i_snooze_p;
  logic                  i_stop_p;
  logic [4:0]            o_hour;
  logic [5:0]            o_min;
  logic [5:0]            o_sec;
  logic [1:0]            o_mode;
  logic [1:0]            o_pos;
  logic [1:0]            o_alarm_idx;
  logic [NUM_ALARMS-1:0] o_alarm_en;
  logic                  o_tick;
  logic                  o_ringing;
  logic [1:0]            o_ring_idx;

  modport master (
    output i_mode_p, i_pos_p, i_inc_p, i_sel_p, i_en_p, i_snooze_p, i_stop_p,
    input  o_hour, o_min, o_sec, o_mode, o_pos, o_alarm_idx, o_alarm_en,
    input  o_tick, o_ringing, o_ring_idx
  );

  modport slave (
    input  i_mode_p, i_pos_p, i_inc_p, i_sel_p, i_en_p, i_snooze_p, i_stop_p,
    output o_hour, o_min, o_sec, o_mode, o_pos, o_alarm_idx, o_alarm_en,
    output o_tick, o_ringing, o_ring_idx
  );
endinterface

// File: rtl/alarm_clock_core.sv
// HH:MM:SS timekeeping core with NUM_ALARMS alarms, a ring/snooze state
// machine and a one-pulse-per-second tick. Single clock, clock enables only.
module alarm_clock_core #(
  parameter int TICK_DIV   = 50_000_000,
  parameter int NUM_ALARMS = 2,
  parameter int RING_SEC   = 60,
  parameter int SNOOZE_SEC = 300
) (
  input  logic              clk,
  input  logic              rst_n,
  alarm_clock_core_if.slave bus
);

  localparam logic [1:0] MODE_CLOCK     = 2'd0;
  localparam logic [1:0] MODE_SET_TIME  = 2'd1;
  localparam logic [1:0] MODE_SET_ALARM = 2'd2;

  localparam logic [1:0] POS_SEC  = 2'd0;
  localparam logic [1:0] POS_MIN  = 2'd1;
  localparam logic [1:0] POS_HOUR = 2'd2;

  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_RING   = 2'd1;
  localparam logic [1:0] ST_SNOOZE = 2'd2;

  localparam int PS_W    = $clog2(TICK_DIV);
  localparam int CNT_MAX = (RING_SEC > SNOOZE_SEC) ? RING_SEC : SNOOZE_SEC;
  localparam int CNT_W   = $clog2(CNT_MAX + 1);

  localparam logic [PS_W-1:0]  PS_LAST     = PS_W'(TICK_DIV - 1);
  localparam logic [CNT_W-1:0] RING_LOAD   = CNT_W'(RING_SEC);
  localparam logic [CNT_W-1:0] SNOOZE_LOAD = CNT_W'(SNOOZE_SEC);
  localparam logic [1:0]       IDX_LAST    = 2'(NUM_ALARMS - 1);

  // Field increments wrap without carrying into neighbouring fields.
  function automatic logic [5:0] inc60(input logic [5:0] v);
    return (v == 6'd59) ? 6'd0 : v + 6'd1;
  endfunction

  function automatic logic [4:0] inc24(input logic [4:0] v);
    return (v == 5'd23) ? 5'd0 : v + 5'd1;
  endfunction

  logic [1:0]            mode_q, mode_d;
  logic [1:0]            pos_q, pos_d;
  logic [1:0]            idx_q, idx_d;
  logic [NUM_ALARMS-1:0] en_q, en_d;
  logic [PS_W-1:0]       ps_q, ps_d;
  logic                  tick_q, tick_d;
  logic                  adv_q, adv_d;
  logic [4:0]            hour_q, hour_d;
  logic [5:0]            min_q, min_d;
  logic [5:0]            sec_q, sec_d;
  logic [4:0]            alm_hour_q [NUM_ALARMS];
  logic [4:0]            alm_hour_d [NUM_ALARMS];
  logic [5:0]            alm_min_q  [NUM_ALARMS];
  logic [5:0]            alm_min_d  [NUM_ALARMS];
  logic [5:0]            alm_sec_q  [NUM_ALARMS];
  logic [5:0]            alm_sec_d  [NUM_ALARMS];
  logic [1:0]            state_q, state_d;
  logic [CNT_W-1:0]      cnt_q, cnt_d;
  logic [1:0]            ring_idx_q, ring_idx_d;
  logic                  ringing_q, ringing_d;

  logic                  edit_inc;
  logic                  hit;
  logic [1:0]            hit_idx;
  logic                  ring_en;

  // A mode pulse swallows every other edit pulse arriving in the same cycle.
  assign edit_inc = bus.i_inc_p & ~bus.i_mode_p;

  // Mode, field position, alarm selection and per-slot enables.
  always_comb begin
    mode_d = mode_q;
    pos_d  = pos_q;
    idx_d  = idx_q;
    en_d   = en_q;
    if (bus.i_mode_p) begin
      mode_d = (mode_q == MODE_SET_ALARM) ? MODE_CLOCK : mode_q + 2'd1;
      pos_d  = POS_SEC;
    end else begin
      if (bus.i_pos_p && (mode_q != MODE_CLOCK)) begin
        pos_d = (pos_q == POS_HOUR) ? POS_SEC : pos_q + 2'd1;
      end
      if (mode_q == MODE_SET_ALARM) begin
        if (bus.i_sel_p) begin
          idx_d = (idx_q == IDX_LAST) ? 2'd0 : idx_q + 2'd1;
        end
        if (bus.i_en_p) begin
          for (int k = 0; k < NUM_ALARMS; k++) begin
            if (idx_q == 2'(k)) en_d[k] = ~en_q[k];
          end
        end
      end
    end
  end

  // Prescaler: frozen at zero while the time is being set, so leaving
  // SET_TIME always restarts a full second.
  always_comb begin
    ps_d   = ps_q + PS_W'(1);
    tick_d = 1'b0;
    if (mode_q == MODE_SET_TIME) begin
      ps_d = '0;
    end else if (ps_q == PS_LAST) begin
      ps_d   = '0;
      tick_d = 1'b1;
    end
  end

  // Time of day: tick-driven carry chain, then any manual field edit.
  always_comb begin
    hour_d = hour_q;
    min_d  = min_q;
    sec_d  = sec_q;
    adv_d  = tick_q;
    if (tick_q) begin
      sec_d = inc60(sec_q);
      if (sec_q == 6'd59) begin
        min_d = inc60(min_q);
        if (min_q == 6'd59) hour_d = inc24(hour_q);
      end
    end
    if (edit_inc && (mode_q == MODE_SET_TIME)) begin
      case (pos_q)
        POS_SEC:  sec_d  = inc60(sec_d);
        POS_MIN:  min_d  = inc60(min_d);
        POS_HOUR: hour_d = inc24(hour_d);
        default:  ;
      endcase
    end
  end

  // Alarm times: only the selected slot's selected field is edited.
  always_comb begin
    alm_hour_d = alm_hour_q;
    alm_min_d  = alm_min_q;
    alm_sec_d  = alm_sec_q;
    if (edit_inc && (mode_q == MODE_SET_ALARM)) begin
      for (int k = 0; k < NUM_ALARMS; k++) begin
        if (idx_q == 2'(k)) begin
          case (pos_q)
            POS_SEC:  alm_sec_d[k]  = inc60(alm_sec_q[k]);
            POS_MIN:  alm_min_d[k]  = inc60(alm_min_q[k]);
            POS_HOUR: alm_hour_d[k] = inc24(alm_hour_q[k]);
            default:  ;
          endcase
        end
      end
    end
  end

  // Lowest enabled slot whose time equals the current time.
  always_comb begin
    hit     = 1'b0;
    hit_idx = 2'd0;
    for (int k = NUM_ALARMS - 1; k >= 0; k--) begin
      if (en_q[k] && (alm_hour_q[k] == hour_q) && (alm_min_q[k] == min_q) &&
          (alm_sec_q[k] == sec_q)) begin
        hit     = 1'b1;
        hit_idx = 2'(k);
      end
    end
  end

  // Enable of the ringing slot as it will be next cycle, so disabling it
  // cancels the ring in the same cycle the toggle lands.
  always_comb begin
    ring_en = 1'b0;
    for (int k = 0; k < NUM_ALARMS; k++) begin
      if (ring_idx_q == 2'(k)) ring_en = en_d[k];
    end
  end

  // Ring / snooze state machine; counters only move on ticks.
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    ring_idx_d = ring_idx_q;
    case (state_q)
      ST_IDLE: begin
        if (adv_q && hit) begin
          state_d    = ST_RING;
          cnt_d      = RING_LOAD;
          ring_idx_d = hit_idx;
        end
      end
      ST_RING: begin
        if (bus.i_stop_p || !ring_en) begin
          state_d = ST_IDLE;
        end else if (bus.i_snooze_p) begin
          state_d = ST_SNOOZE;
          cnt_d   = SNOOZE_LOAD;
        end else if (tick_q) begin
          if (cnt_q <= CNT_W'(1)) state_d = ST_IDLE;
          else                    cnt_d   = cnt_q - CNT_W'(1);
        end
      end
      ST_SNOOZE: begin
        if (bus.i_stop_p || !ring_en) begin
          state_d = ST_IDLE;
        end else if (tick_q) begin
          if (cnt_q <= CNT_W'(1)) begin
            state_d = ST_RING;
            cnt_d   = RING_LOAD;
          end else begin
            cnt_d = cnt_q - CNT_W'(1);
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
    ringing_d = (state_d == ST_RING);
  end

  // State registers, all cleared asynchronously.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mode_q     <= MODE_CLOCK;
      pos_q      <= POS_SEC;
      idx_q      <= 2'd0;
      en_q       <= '0;
      ps_q       <= '0;
      tick_q     <= 1'b0;
      adv_q      <= 1'b0;
      hour_q     <= 5'd0;
      min_q      <= 6'd0;
      sec_q      <= 6'd0;
      for (int k = 0; k < NUM_ALARMS; k++) begin
        alm_hour_q[k] <= 5'd0;
        alm_min_q[k]  <= 6'd0;
        alm_sec_q[k]  <= 6'd0;
      end
      state_q    <= ST_IDLE;
      cnt_q      <= '0;
      ring_idx_q <= 2'd0;
      ringing_q  <= 1'b0;
    end else begin
      mode_q     <= mode_d;
      pos_q      <= pos_d;
      idx_q      <= idx_d;
      en_q       <= en_d;
      ps_q       <= ps_d;
      tick_q     <= tick_d;
      adv_q      <= adv_d;
      hour_q     <= hour_d;
      min_q      <= min_d;
      sec_q      <= sec_d;
      alm_hour_q <= alm_hour_d;
      alm_min_q  <= alm_min_d;
      alm_sec_q  <= alm_sec_d;
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      ring_idx_q <= ring_idx_d;
      ringing_q  <= ringing_d;
    end
  end

  // Display mux: the selected alarm in SET_ALARM, otherwise the time.
  always_comb begin
    bus.o_hour = hour_q;
    bus.o_min  = min_q;
    bus.o_sec  = sec_q;
    if (mode_q == MODE_SET_ALARM) begin
      for (int k = 0; k < NUM_ALARMS; k++) begin
        if (idx_q == 2'(k)) begin
          bus.o_hour = alm_hour_q[k];
          bus.o_min  = alm_min_q[k];
          bus.o_sec  = alm_sec_q[k];
        end
      end
    end
  end

  assign bus.o_mode      = mode_q;
  assign bus.o_pos       = pos_q;
  assign bus.o_alarm_idx = idx_q;
  assign bus.o_alarm_en  = en_q;
  assign bus.o_tick      = tick_q;
  assign bus.o_ringing   = ringing_q;
  assign bus.o_ring_idx  = ring_idx_q;

endmodule
